// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the early-exit divider:
//                FSM state encoding, operand/index widths, the registered
//                result bundle and a conditional two's-complement helper.
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

  localparam int DIV_WIDTH     = 32;
  localparam int DIV_IDX_WIDTH = 5;
  localparam int DIV_ID_WIDTH  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0]    quotient;
    logic [DIV_WIDTH-1:0]    remainder;
    logic [DIV_ID_WIDTH-1:0] id;
  } div_result_t;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [DIV_WIDTH-1:0] cond_negate(
    input logic [DIV_WIDTH-1:0] v,
    input logic                 neg
  );
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/early_exit_divider_msb.sv
`default_nettype none
// ============================================================================
//  Module      : early_exit_divider_msb
//  Description : Leading-one detector. Returns the index of the highest set
//                bit of value_i; an all-zero input reports index 0, so the
//                caller must detect zero separately.
//  Ports       : value_i  in  DIV_WIDTH      word to scan
//                msb_o    out DIV_IDX_WIDTH  index of the most significant 1
//  Revision    : 1.0  initial release
// ============================================================================
module early_exit_divider_msb
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0]     value_i,
  output logic [DIV_IDX_WIDTH-1:0] msb_o
);

  always_comb begin
    msb_o = '0;
    for (int i = 0; i < DIV_WIDTH; i++) begin
      if (value_i[i]) begin
        msb_o = DIV_IDX_WIDTH'(i);
      end
    end
  end

endmodule : early_exit_divider_msb
`default_nettype wire

// File: rtl/early_exit_divider.sv
`default_nettype none
// ============================================================================
//  Module      : early_exit_divider
//  Description : Iterative radix-2 32-bit divider. Two leading-one detectors
//                pre-align the divisor so only msb(a)-msb(b)+1 iterations
//                run. One operation in flight, valid/ready on both sides.
//  Ports       : clk, rst (async, active-high)
//                in_valid/in_ready, dividend, divisor, is_signed, in_id
//                out_valid/out_ready, quotient, remainder, out_id
//  Config      : DIV_SIGNED_EN - when defined, is_signed=1 selects a
//                two's-complement divide; otherwise is_signed is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module early_exit_divider
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  is_signed,
  input  logic [ID_WIDTH-1:0]   in_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic [ID_WIDTH-1:0]   out_id
);

  logic                     a_neg_w, b_neg_w;
  logic [DIV_WIDTH-1:0]     a_mag_w, b_mag_w;
  logic [DIV_IDX_WIDTH-1:0] msb_a_w, msb_b_w, diff_w;

`ifdef DIV_SIGNED_EN
  assign a_neg_w = is_signed & dividend[DIV_WIDTH-1];
  assign b_neg_w = is_signed & divisor[DIV_WIDTH-1];
`else
  logic signed_unused;
  assign signed_unused = is_signed;
  assign a_neg_w = 1'b0;
  assign b_neg_w = 1'b0;
`endif

  // MIN's magnitude 0x80000000 is exact when read as unsigned.
  assign a_mag_w = cond_negate(dividend, a_neg_w);
  assign b_mag_w = cond_negate(divisor, b_neg_w);

  early_exit_divider_msb u_msb_a (.value_i(a_mag_w), .msb_o(msb_a_w));
  early_exit_divider_msb u_msb_b (.value_i(b_mag_w), .msb_o(msb_b_w));

  // Only consumed when |a|>=|b|, which guarantees msb_a>=msb_b.
  assign diff_w = msb_a_w - msb_b_w;

  div_state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0]     rem_q, rem_d;
  logic [DIV_WIDTH-1:0]     d_q, d_d;
  logic [DIV_WIDTH-1:0]     q_q, q_d;
  logic [DIV_IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic                     qneg_q, qneg_d;
  logic                     rneg_q, rneg_d;
  logic [DIV_ID_WIDTH-1:0]  id_q, id_d;
  div_result_t              res_q, res_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      d_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      id_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      d_q     <= d_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      id_q    <= id_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    d_d     = d_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    id_d    = id_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          id_d   = DIV_ID_WIDTH'(in_id);
          qneg_d = a_neg_w ^ b_neg_w;
          rneg_d = a_neg_w;
          rem_d  = a_mag_w;
          q_d    = '0;
          d_d    = b_mag_w << diff_w;
          cnt_d  = diff_w;
          if (divisor == '0) begin
            state_d         = DONE;
            res_d.quotient  = '1;
            res_d.remainder = dividend;
            res_d.id        = DIV_ID_WIDTH'(in_id);
          end else if (a_mag_w < b_mag_w) begin
            // Quotient 0; remainder is |a| re-signed, i.e. the dividend.
            state_d         = DONE;
            res_d.quotient  = '0;
            res_d.remainder = dividend;
            res_d.id        = DIV_ID_WIDTH'(in_id);
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (rem_q >= d_q) begin
          rem_d = rem_q - d_q;
          q_d   = {q_q[DIV_WIDTH-2:0], 1'b1};
        end else begin
          q_d   = {q_q[DIV_WIDTH-2:0], 1'b0};
        end
        d_d = d_q >> 1;
        if (cnt_q == '0) begin
          // Sign fixup folds into the DONE entry, so latency is unaffected.
          state_d         = DONE;
          res_d.quotient  = cond_negate(q_d, qneg_q);
          res_d.remainder = cond_negate(rem_d, rneg_q);
          res_d.id        = id_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = res_q.quotient;
  assign remainder = res_q.remainder;
  assign out_id    = ID_WIDTH'(res_q.id);

endmodule : early_exit_divider
`default_nettype wire

// File: tb/tb_early_exit_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_early_exit_divider
//  Description : Scoreboard bench for early_exit_divider. Stimulus pushes the
//                reference-model result (plain integer arithmetic) on accept;
//                a monitor pops and compares on each new out_valid, and checks
//                that held outputs stay stable under backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_early_exit_divider;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        is_signed = 1'b0;
  logic [1:0]  in_id = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [1:0]  out_id;

  early_exit_divider #(.DATA_WIDTH(32), .ID_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .out_id(out_id)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [1:0]  id;
    longint      lat;
    longint      t_acc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic longint msb_of(input logic [31:0] x);
    return longint'($clog2({1'b0, x} + 33'd1)) - 1;
  endfunction

  // Reference: truncating integer division on 64-bit values, which gives
  // remainder-takes-dividend-sign and a non-overflowing MIN/-1.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic [1:0] id);
    exp_t   e;
    bit     sg;
    longint sa, sbv, qa, ra, ma, mb;
    sg = s & SIGNED_BUILD;
    sa  = sg ? longint'($signed(a)) : longint'({32'b0, a});
    sbv = sg ? longint'($signed(b)) : longint'({32'b0, b});
    ma = (sa < 0) ? -sa : sa;
    mb = (sbv < 0) ? -sbv : sbv;
    e.id = id;
    e.t_acc = 0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.lat = 1;
    end else begin
      qa = sa / sbv;
      ra = sa % sbv;
      e.q = qa[31:0];
      e.r = ra[31:0];
      if (ma < mb) e.lat = 1;
      else e.lat = msb_of(ma[31:0]) - msb_of(mb[31:0]) + 2;
    end
    return e;
  endfunction

  // Monitor: sampled 1 time unit after the falling edge.
  exp_t cur;
  bit   have_cur = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      have_cur = 1'b0;
    end else if (out_valid) begin
      if (!have_cur) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          check("quotient", {32'b0, quotient}, {32'b0, cur.q});
          check("remainder", {32'b0, remainder}, {32'b0, cur.r});
          check("out_id", {62'b0, out_id}, {62'b0, cur.id});
          check("latency", 64'(cyc - cur.t_acc), 64'(cur.lat));
        end
      end else begin
        check("hold_quotient", {32'b0, quotient}, {32'b0, cur.q});
        check("hold_remainder", {32'b0, remainder}, {32'b0, cur.r});
        check("hold_out_id", {62'b0, out_id}, {62'b0, cur.id});
      end
      check("in_ready_in_done", {63'b0, in_ready}, 64'd0);
      if (out_ready) have_cur = 1'b0;
    end
  end

  always @(negedge clk) if (rand_rdy) out_ready = 1'($urandom_range(0, 1));

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [1:0] id);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd1, 64'd0);
      return;
    end
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_id     = id;
    in_valid  = 1'b1;
    e = model(a, b, s, id);
    e.t_acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;

    // Reset state (outputs checked while reset is held).
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_quotient", {32'b0, quotient}, 64'd0);
    check("rst_remainder", {32'b0, remainder}, 64'd0);
    check("rst_out_id", {62'b0, out_id}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Directed cases.
    do_op(32'd100, 32'd7, 1'b0, 2'd2);
    do_op(32'h1234, 32'd0, 1'b0, 2'd1);
    do_op(32'd5, 32'd9, 1'b0, 2'd3);
    do_op(32'd0, 32'd3, 1'b0, 2'd0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 2'd1);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 2'd2);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 2'd3);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 2'd0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2'd1);

    // Backpressure: hold out_ready low for 3 cycles in DONE.
    @(negedge clk);
    while (out_valid) @(negedge clk);
    out_ready = 1'b0;
    do_op(32'd1000, 32'd10, 1'b0, 2'd2);
    wait_valid();
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);

    // Reset during a long op: aborts, outputs cleared, then recover.
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 2'd3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_out_valid", {63'b0, out_valid}, 64'd0);
    check("abort_quotient", {32'b0, quotient}, 64'd0);
    check("abort_remainder", {32'b0, remainder}, 64'd0);
    check("abort_out_id", {62'b0, out_id}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", {63'b0, in_ready}, 64'd1);
    do_op(32'd100, 32'd7, 1'b0, 2'd2);

    // Randomised ops with random consumer backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) rb = 32'hFFFF_FFFF;
      do_op(ra, rb, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;

    // Drain: every pushed result must have been presented.
    for (int n = 0; n < 200 && (sb.size() != 0 || out_valid); n++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_early_exit_divider
`default_nettype wire
